oam_dma_ctrl: RTL and testbench

//  Initiator-side engine driving the dual-port BRAM: GB/GBC OAM DMA. A CPU write to FF46 starts
//  a 160-byte copy from source {page,8'h00} to OAM index 0..159. The engine issues reads on a

---
 rtl/gb_dma_pkg.sv | 22 ++
 rtl/dma_slot_timer.sv | 28 ++
 rtl/oam_dma_ctrl.sv | 108 ++++++++++
 tb/tb_oam_dma_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/gb_dma_pkg.sv
// Shared types and constants for the OAM DMA engine.
package gb_dma_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDly,
    StRd,
    StCap,
    StWr,
    StGap
  } dma_state_e;

  localparam logic [15:0] REG_ADDR_FF46 = 16'hFF46;
  localparam int unsigned OAM_LEN       = 160;
  localparam logic [7:0]  ECHO_BASE     = 8'hE0;

  // Pages E0..FF alias work RAM at C0..DF.
  function automatic logic [7:0] eff_page(input logic [7:0] page);
    return (page >= ECHO_BASE) ? page - 8'h20 : page;
  endfunction

endpackage

// File: rtl/dma_slot_timer.sv
// Byte-slot counter for the OAM DMA engine: counts 0..CYC_PER_BYTE-1 and flags the last clock.
module dma_slot_timer #(
  parameter int unsigned CYC_PER_BYTE = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic slot_end_o
);

  localparam int unsigned SW = $clog2(CYC_PER_BYTE);

  logic [SW-1:0] s_q, s_d;

  assign slot_end_o = en_i && (s_q == SW'(CYC_PER_BYTE - 1));

  always_comb begin
    s_d = s_q + 1'b1;
    if (clr_i || !en_i || slot_end_o) s_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) s_q <= '0;
    else       s_q <= s_d;
  end

endmodule

// File: rtl/oam_dma_ctrl.sv
// GB/GBC OAM DMA engine: copies LEN bytes from {page,00} into OAM after a write to FF46.
// Build option OAM_DMA_STARTUP_DELAY_EN inserts one idle slot before the first read.
module oam_dma_ctrl
  import gb_dma_pkg::*;
#(
  parameter int unsigned LEN          = OAM_LEN,
  parameter int unsigned CYC_PER_BYTE = 4,
  parameter logic [15:0] REG_ADDR     = REG_ADDR_FF46
) (
  input  logic        clka,
  input  logic        rsta,
  input  logic        reg_we,
  input  logic [15:0] reg_addr,
  input  logic [7:0]  reg_din,
  output logic [7:0]  reg_dout,
  output logic        busy,
  output logic        src_en,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_din,
  output logic        oam_en,
  output logic        oam_we,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_dout
);

`ifdef OAM_DMA_STARTUP_DELAY_EN
  localparam dma_state_e StStart = StDly;
`else
  localparam dma_state_e StStart = StRd;
`endif

  dma_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] page_q;
  logic [7:0] data_q;
  logic       trig;
  logic       slot_end;
  logic       last;

  assign trig = reg_we && (reg_addr == REG_ADDR);
  assign last = (idx_q == 8'(LEN - 1));

  dma_slot_timer #(
    .CYC_PER_BYTE (CYC_PER_BYTE)
  ) u_slot_timer (
    .clk_i      (clka),
    .rst_i      (rsta),
    .clr_i      (trig),
    .en_i       (state_q != StIdle),
    .slot_end_o (slot_end)
  );

  always_ff @(posedge clka) begin
    if (rsta) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // A trigger always wins, including over the final slot end.
  always_comb begin
    state_d = state_q;
    if (trig) begin
      state_d = StStart;
    end else begin
      unique case (state_q)
        StIdle:       state_d = StIdle;
        StDly:        if (slot_end) state_d = StRd;
        StRd:         state_d = StCap;
        StCap:        state_d = StWr;
        StWr, StGap:  state_d = slot_end ? (last ? StIdle : StRd) : StGap;
        default:      state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    idx_d = idx_q;
    if (trig) begin
      idx_d = '0;
    end else if (slot_end && state_q != StDly && state_q != StIdle) begin
      idx_d = last ? 8'd0 : idx_q + 8'd1;
    end
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      idx_q  <= '0;
      page_q <= '0;
      data_q <= '0;
    end else begin
      idx_q <= idx_d;
      if (trig)             page_q <= reg_din;
      if (state_q == StCap) data_q <= src_din;
    end
  end

  // The write on a restart edge is dropped so a half-finished slot never lands in OAM.
  always_comb begin
    reg_dout = page_q;
    busy     = (state_q != StIdle);
    src_en   = (state_q == StRd);
    src_addr = src_en ? {eff_page(page_q), idx_q} : 16'h0000;
    oam_en   = (state_q == StWr) && !trig;
    oam_we   = oam_en;
    oam_addr = (state_q == StWr) ? idx_q : 8'h00;
    oam_dout = (state_q == StWr) ? data_q : 8'h00;
  end

endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl; honours OAM_DMA_STARTUP_DELAY_EN for expected timing.
module tb_oam_dma_ctrl;

`ifdef OAM_DMA_STARTUP_DELAY_EN
  localparam int FIRST_SRC = 5;
  localparam int BUSY_EXP  = 644;
`else
  localparam int FIRST_SRC = 1;
  localparam int BUSY_EXP  = 640;
`endif

  logic        clka = 1'b0;
  logic        rsta;
  logic        reg_we;
  logic [15:0] reg_addr;
  logic [7:0]  reg_din;
  logic [7:0]  reg_dout;
  logic        busy;
  logic        src_en;
  logic [15:0] src_addr;
  logic [7:0]  src_din = 8'h00;
  logic        oam_en;
  logic        oam_we;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_dout;

  int errors = 0;
  int checks = 0;

  oam_dma_ctrl u_dut (
    .clka     (clka),
    .rsta     (rsta),
    .reg_we   (reg_we),
    .reg_addr (reg_addr),
    .reg_din  (reg_din),
    .reg_dout (reg_dout),
    .busy     (busy),
    .src_en   (src_en),
    .src_addr (src_addr),
    .src_din  (src_din),
    .oam_en   (oam_en),
    .oam_we   (oam_we),
    .oam_addr (oam_addr),
    .oam_dout (oam_dout)
  );

  always #5 clka = ~clka;

  // Source memory holds addr[7:0]^5A; OAM is a plain write port model.
  logic [7:0] oam_mem [256];
  logic       oam_init;

  always @(posedge clka) begin
    if (src_en) src_din <= src_addr[7:0] ^ 8'h5A;
  end

  always @(posedge clka) begin
    if (oam_init) begin
      for (int i = 0; i < 256; i++) oam_mem[i] <= 8'hEE;
    end else if (oam_en && oam_we) begin
      oam_mem[oam_addr] <= oam_dout;
    end
  end

  // Strobe monitor, cleared by mon_clr; cycle 1 is the clock after the trigger edge.
  logic       mon_clr;
  logic [7:0] exp_page;
  int cyc, c, busy_cnt, n_src, n_we, first_src, last_src, src_bad, gap_bad, we_bad;

  always @(negedge clka) begin
    if (mon_clr) begin
      cyc <= 0; busy_cnt <= 0; n_src <= 0; n_we <= 0; first_src <= 0; last_src <= 0;
      src_bad <= 0; gap_bad <= 0; we_bad <= 0;
    end else begin
      c = cyc + 1;
      cyc <= c;
      if (busy) busy_cnt <= busy_cnt + 1;
      if (src_en) begin
        if (src_addr !== {exp_page, n_src[7:0]}) src_bad <= src_bad + 1;
        if (n_src == 0) first_src <= c;
        else if (c != last_src + 4) gap_bad <= gap_bad + 1;
        last_src <= c;
        n_src    <= n_src + 1;
      end
      if (oam_en && oam_we) begin
        if (oam_addr !== n_we[7:0] || c != last_src + 2 ||
            oam_dout !== (n_we[7:0] ^ 8'h5A)) we_bad <= we_bad + 1;
        n_we <= n_we + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [15:0] a, input logic [7:0] d, input logic [7:0] ep);
    @(posedge clka); #1;
    reg_we = 1'b1; reg_addr = a; reg_din = d; exp_page = ep; mon_clr = 1'b1;
    @(posedge clka); #1;
    reg_we = 1'b0; mon_clr = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clka);
      if (!busy) done = 1'b1;
    end
    #1;
    check({tag, "_done"}, done, 1);
  endtask

  task automatic check_xfer(input string tag);
    check({tag, "_nsrc"},  n_src,     160);
    check({tag, "_saddr"}, src_bad,   0);
    check({tag, "_first"}, first_src, FIRST_SRC);
    check({tag, "_gap"},   gap_bad,   0);
    check({tag, "_nwe"},   n_we,      160);
    check({tag, "_we"},    we_bad,    0);
    check({tag, "_busy"},  busy_cnt,  BUSY_EXP);
  endtask

  task automatic run_xfer(input logic [7:0] page, input logic [7:0] ep, input string tag);
    write_reg(16'hFF46, page, ep);
    @(negedge clka);
    check({tag, "_busy1"}, busy, 1);
    check({tag, "_rdout"}, reg_dout, page);
    wait_idle(tag);
    check_xfer(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    int bad;
    rsta = 1'b1; reg_we = 1'b0; reg_addr = '0; reg_din = '0;
    mon_clr = 1'b1; oam_init = 1'b1; exp_page = '0;
    repeat (3) @(posedge clka);
    #1;
    rsta = 1'b0; oam_init = 1'b0; mon_clr = 1'b0;
    @(negedge clka);
    check("rst_busy",  busy,     0);
    check("rst_srcen", src_en,   0);
    check("rst_oamen", {oam_en, oam_we}, 0);
    check("rst_saddr", src_addr, 0);
    check("rst_oaddr", oam_addr, 0);
    check("rst_odout", oam_dout, 0);
    check("rst_rdout", reg_dout, 0);

    // Plain transfer and resulting OAM contents
    run_xfer(8'hC1, 8'hC1, "c1");
    bad = 0;
    for (int i = 0; i < 160; i++) if (oam_mem[i] !== (i[7:0] ^ 8'h5A)) bad++;
    check("oam_data", bad, 0);
    check("oam_160", oam_mem[160], 8'hEE);

    // Echo remap and the page just below it
    run_xfer(8'hFE, 8'hDE, "fe");
    run_xfer(8'hDF, 8'hDF, "df");

    // Restart on the WR edge of idx 50
    write_reg(16'hFF46, 8'hC1, 8'hC1);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clka); #1;
      if (oam_we && oam_addr == 8'd50) found = 1'b1;
    end
    check("rs_find", found, 1);
    reg_we = 1'b1; reg_addr = 16'hFF46; reg_din = 8'h80; exp_page = 8'h80; mon_clr = 1'b1;
    #1;
    check("rs_we_sup", {oam_en, oam_we}, 0);
    @(posedge clka); #1;
    reg_we = 1'b0; mon_clr = 1'b0;
    @(negedge clka);
    check("rs_busy", busy, 1);
`ifndef OAM_DMA_STARTUP_DELAY_EN
    check("rs_srcen", src_en, 1);
    check("rs_saddr", src_addr, 16'h8000);
`endif
    wait_idle("rs");
    check_xfer("rs");

    // Reset mid-transfer at idx 100
    write_reg(16'hFF46, 8'hC1, 8'hC1);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clka); #1;
      if (src_en && src_addr[7:0] == 8'd100) found = 1'b1;
    end
    check("rr_find", found, 1);
    rsta = 1'b1;
    @(posedge clka); #1;
    rsta = 1'b0;
    check("rr_strobes", {busy, src_en, oam_en, oam_we}, 0);
    check("rr_data", {src_addr, oam_addr, oam_dout}, 0);
    check("rr_rdout", reg_dout, 0);
    mon_clr = 1'b1;
    @(posedge clka); #1;
    mon_clr = 1'b0;
    repeat (20) @(negedge clka);
    #1;
    check("rr_quiet", n_src + n_we + busy_cnt, 0);
    run_xfer(8'hC1, 8'hC1, "post_rst");

    // Neighbouring register address does nothing
    write_reg(16'hFF47, 8'h33, 8'h00);
    repeat (10) @(negedge clka);
    #1;
    check("ff47_quiet", n_src + n_we + busy_cnt, 0);
    check("ff47_rdout", reg_dout, 8'hC1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
